// File: rtl/display_port_bridge_if.sv
// Port bus between a kcpsm3-style CPU and the display bridge, plus the display-memory write side.
interface display_port_bridge_if #(
  parameter int unsigned COL_BITS = 7,
  parameter int unsigned ROW_BITS = 5
) ();
  logic [7:0]                   port_id;
  logic                         write_strobe;
  logic                         read_strobe;
  logic [7:0]                   out_port;
  logic [7:0]                   in_port;
  logic [COL_BITS+ROW_BITS-1:0] dsp_addr;
  logic                         dsp_wr;
  logic [15:0]                  dsp_data;
  logic                         busy;

  modport master (
    output port_id, write_strobe, read_strobe, out_port,
    input  in_port, dsp_addr, dsp_wr, dsp_data, busy
  );

  modport slave (
    input  port_id, write_strobe, read_strobe, out_port,
    output in_port, dsp_addr, dsp_wr, dsp_data, busy
  );
endinterface

// File: rtl/display_port_bridge.sv
// Port-mapped text cursor for the character display: CHAR writes one cell and advances,
// plus newline and a hardware clear-screen sequencer.
module display_port_bridge #(
  parameter int unsigned COL_BITS     = 7,
  parameter int unsigned ROW_BITS     = 5,
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter logic [7:0]  ATTR_DEFAULT = 8'h0F,
  parameter logic [7:0]  PORT_BASE    = 8'h80
) (
  input logic                   clk,
  input logic                   reset,
  display_port_bridge_if.slave  bus
);

  localparam int unsigned AddrBits = COL_BITS + ROW_BITS;
  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;
  localparam logic [COL_BITS-1:0] LastCol = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LastRow = ROW_BITS'(ROWS - 1);

  logic [0:0]          stateQ;
  logic [COL_BITS-1:0] colQ;
  logic [ROW_BITS-1:0] rowQ;
  logic [7:0]          attrQ;
  logic                dspWrQ;
  logic [AddrBits-1:0] dspAddrQ;
  logic [15:0]         dspDataQ;

  logic                hit;
  logic                wrEn;
  logic [COL_BITS-1:0] colSat;
  logic [ROW_BITS-1:0] rowSat;
  logic [7:0]          inPort;
  logic                unusedReadStrobe;

  // Row-major successor of a visible cell; wraps from the last cell back to (0,0).
  function automatic logic [AddrBits-1:0] nextCell(input logic [ROW_BITS-1:0] r,
                                                   input logic [COL_BITS-1:0] c);
    if (c != LastCol) return {r, c + COL_BITS'(1)};
    if (r != LastRow) return {r + ROW_BITS'(1), {COL_BITS{1'b0}}};
    return '0;
  endfunction

  assign hit              = (bus.port_id[7:3] == PORT_BASE[7:3]);
  assign wrEn             = bus.write_strobe & hit;
  assign colSat           = (32'(bus.out_port) >= COLS) ? LastCol : COL_BITS'(bus.out_port);
  assign rowSat           = (32'(bus.out_port) >= ROWS) ? LastRow : ROW_BITS'(bus.out_port);
  assign unusedReadStrobe = bus.read_strobe;

  always_comb begin
    inPort = 8'h00;
    if (hit) begin
      case (bus.port_id[2:0])
        3'd1:    inPort = 8'(colQ);
        3'd2:    inPort = 8'(rowQ);
        3'd3:    inPort = attrQ;
        3'd4:    inPort = {7'b0, stateQ == StClear};
        default: inPort = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= StIdle;
      colQ     <= '0;
      rowQ     <= '0;
      attrQ    <= ATTR_DEFAULT;
      dspWrQ   <= 1'b0;
      dspAddrQ <= '0;
      dspDataQ <= '0;
    end else begin
      dspWrQ <= 1'b0;
      if (stateQ == StIdle) begin
        if (wrEn) begin
          case (bus.port_id[2:0])
            3'd0: begin
              dspWrQ       <= 1'b1;
              dspAddrQ     <= {rowQ, colQ};
              dspDataQ     <= {attrQ, bus.out_port};
              {rowQ, colQ} <= nextCell(rowQ, colQ);
            end
            3'd1: colQ  <= colSat;
            3'd2: rowQ  <= rowSat;
            3'd3: attrQ <= bus.out_port;
            3'd4: begin
              if (bus.out_port[0]) begin
                // The first blank cell goes out on the same edge the clear is accepted.
                stateQ   <= StClear;
                dspWrQ   <= 1'b1;
                dspAddrQ <= '0;
                dspDataQ <= {attrQ, 8'h20};
              end else if (bus.out_port[1]) begin
                {rowQ, colQ} <= nextCell(rowQ, LastCol);
              end
            end
            default: ;
          endcase
        end
      end else begin
        // dspAddrQ doubles as the clear pointer; attr cannot change while busy.
        if (dspAddrQ == {LastRow, LastCol}) begin
          stateQ <= StIdle;
          colQ   <= '0;
          rowQ   <= '0;
        end else begin
          dspWrQ   <= 1'b1;
          dspAddrQ <= nextCell(dspAddrQ[AddrBits-1:COL_BITS], dspAddrQ[COL_BITS-1:0]);
        end
      end
    end
  end

  assign bus.in_port  = inPort;
  assign bus.dsp_wr   = dspWrQ;
  assign bus.dsp_addr = dspAddrQ;
  assign bus.dsp_data = dspDataQ;
  assign bus.busy     = (stateQ == StClear);

endmodule

// File: tb/tb_display_port_bridge.sv
// Self-checking bench for display_port_bridge: vector table, clear/reset sequences and
// randomized traffic against a linear-cursor reference model.
module tb_display_port_bridge;

  localparam int Cols  = 80;
  localparam int Rows  = 30;
  localparam int Cells = Cols * Rows;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  display_port_bridge_if #(.COL_BITS(7), .ROW_BITS(5)) bus ();

  display_port_bridge #(
    .COL_BITS(7), .ROW_BITS(5), .COLS(80), .ROWS(30),
    .ATTR_DEFAULT(8'h0F), .PORT_BASE(8'h80)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         we;
    logic [7:0] id;
    logic [7:0] wd;
    logic [7:0] rdId;
    logic [7:0] expRd;
    bit         expWr;
    logic [11:0] expAddr;
    logic [15:0] expData;
  } vec_t;

  vec_t vecs[$];

  // Reference model: cursor as a linear cell index, attribute byte.
  int         pos;
  logic [7:0] mAttr;

  function automatic logic [11:0] cellAddr(input int p);
    return 12'(((p / Cols) * 128) + (p % Cols));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input bit we, input logic [7:0] id, input logic [7:0] wd,
                        input logic [7:0] rdId, input logic [7:0] expRd, input bit expWr,
                        input logic [11:0] expAddr, input logic [15:0] expData);
    vec_t v;
    v.we = we; v.id = id; v.wd = wd; v.rdId = rdId; v.expRd = expRd;
    v.expWr = expWr; v.expAddr = expAddr; v.expData = expData;
    vecs.push_back(v);
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    @(negedge clk);
    bus.port_id      = id;
    bus.out_port     = d;
    bus.write_strobe = 1'b1;
    @(negedge clk);
    bus.write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] v);
    bus.port_id = id;
    #1;
    v = bus.in_port;
  endtask

  task automatic doReset();
    reset            = 1'b1;
    bus.port_id      = 8'h00;
    bus.out_port     = 8'h00;
    bus.write_strobe = 1'b0;
    bus.read_strobe  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pos   = 0;
    mAttr = 8'h0F;
  endtask

  // Samples a running clear from the current negedge until busy and dsp_wr both drop.
  task automatic runClear(input bit inject, output int pulses, output int busyCyc,
                          output int bad, output logic [7:0] ctrlRd);
    logic [7:0] v;
    pulses = 0; busyCyc = 0; bad = 0; ctrlRd = 8'hFF;
    for (int c = 0; c < Cells + 200; c++) begin
      if (!bus.busy && !bus.dsp_wr) break;
      if (bus.busy) busyCyc++;
      if (bus.dsp_wr) begin
        if (bus.dsp_addr !== cellAddr(pulses) || bus.dsp_data !== 16'h1E20) bad++;
        pulses++;
      end
      if (c == 3) begin
        rd(8'h84, v);
        ctrlRd = v;
      end
      if (inject) begin
        if (c == 10) begin bus.port_id = 8'h80; bus.out_port = 8'h43; bus.write_strobe = 1'b1; end
        if (c == 11) begin bus.port_id = 8'h81; bus.out_port = 8'h05; end
        if (c == 12) begin bus.port_id = 8'h83; bus.out_port = 8'h77; end
        if (c == 13) bus.write_strobe = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  v;
    logic [7:0]  id;
    logic [7:0]  d;
    int          pulses, busyCyc, bad, op, r;
    logic [11:0] eAddr;
    logic [15:0] eData;

    doReset();
    check("reset dsp_wr", 32'(bus.dsp_wr), 32'd0);
    check("reset dsp_addr", 32'(bus.dsp_addr), 32'd0);
    check("reset dsp_data", 32'(bus.dsp_data), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);

    //      we  id     wd     rdId   expRd  wr  addr     data
    addVec(0, 8'h00, 8'h00, 8'h83, 8'h0F, 0, 12'h000, 16'h0000);
    addVec(0, 8'h00, 8'h00, 8'h84, 8'h00, 0, 12'h000, 16'h0000);
    addVec(1, 8'h80, 8'h41, 8'h81, 8'h01, 1, 12'h000, 16'h0F41);
    addVec(1, 8'h81, 8'h4F, 8'h81, 8'h4F, 0, 12'h000, 16'h0000);
    addVec(1, 8'h82, 8'h1D, 8'h82, 8'h1D, 0, 12'h000, 16'h0000);
    addVec(1, 8'h80, 8'h42, 8'h81, 8'h00, 1, 12'hECF, 16'h0F42);
    addVec(0, 8'h00, 8'h00, 8'h82, 8'h00, 0, 12'h000, 16'h0000);
    addVec(1, 8'h81, 8'd100, 8'h81, 8'h4F, 0, 12'h000, 16'h0000);
    addVec(1, 8'h82, 8'd31, 8'h82, 8'h1D, 0, 12'h000, 16'h0000);
    addVec(1, 8'h81, 8'h0A, 8'h81, 8'h0A, 0, 12'h000, 16'h0000);
    addVec(1, 8'h82, 8'h03, 8'h82, 8'h03, 0, 12'h000, 16'h0000);
    addVec(1, 8'h84, 8'h02, 8'h82, 8'h04, 0, 12'h000, 16'h0000);
    addVec(0, 8'h00, 8'h00, 8'h81, 8'h00, 0, 12'h000, 16'h0000);
    addVec(1, 8'h82, 8'h1D, 8'h82, 8'h1D, 0, 12'h000, 16'h0000);
    addVec(1, 8'h84, 8'h02, 8'h82, 8'h00, 0, 12'h000, 16'h0000);
    addVec(1, 8'h85, 8'h55, 8'h85, 8'h00, 0, 12'h000, 16'h0000);
    addVec(1, 8'h03, 8'hFF, 8'h83, 8'h0F, 0, 12'h000, 16'h0000);
    addVec(1, 8'h81, 8'h07, 8'h01, 8'h00, 0, 12'h000, 16'h0000);
    addVec(1, 8'h00, 8'h41, 8'h81, 8'h07, 0, 12'h000, 16'h0000);
    addVec(1, 8'h80, 8'h00, 8'h80, 8'h00, 1, 12'h007, 16'h0F00);
    addVec(1, 8'h83, 8'h1E, 8'h83, 8'h1E, 0, 12'h000, 16'h0000);

    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].id, vecs[i].wd);
      else @(negedge clk);
      check($sformatf("vec%0d dsp_wr", i), 32'(bus.dsp_wr), 32'(vecs[i].expWr));
      if (vecs[i].expWr) begin
        check($sformatf("vec%0d dsp_addr", i), 32'(bus.dsp_addr), 32'(vecs[i].expAddr));
        check($sformatf("vec%0d dsp_data", i), 32'(bus.dsp_data), 32'(vecs[i].expData));
      end
      rd(vecs[i].rdId, v);
      check($sformatf("vec%0d in_port", i), 32'(v), 32'(vecs[i].expRd));
    end

    // Back-to-back CHAR writes; cursor is at (0,8), attr 1E.
    @(negedge clk);
    bus.port_id = 8'h80; bus.out_port = 8'h61; bus.write_strobe = 1'b1;
    @(negedge clk);
    check("b2b first wr", 32'(bus.dsp_wr), 32'd1);
    check("b2b first addr", 32'(bus.dsp_addr), 32'h008);
    check("b2b first data", 32'(bus.dsp_data), 32'h1E61);
    bus.out_port = 8'h62;
    @(negedge clk);
    check("b2b second wr", 32'(bus.dsp_wr), 32'd1);
    check("b2b second addr", 32'(bus.dsp_addr), 32'h009);
    check("b2b second data", 32'(bus.dsp_data), 32'h1E62);
    bus.write_strobe = 1'b0;
    @(negedge clk);
    check("b2b idle wr", 32'(bus.dsp_wr), 32'd0);

    // Full clear with the cursor parked away from the origin.
    wr(8'h81, 8'd12);
    wr(8'h82, 8'd5);
    wr(8'h84, 8'h01);
    runClear(1'b0, pulses, busyCyc, bad, v);
    check("clear pulses", 32'(pulses), 32'(Cells));
    check("clear busy cycles", 32'(busyCyc), 32'(Cells));
    check("clear cell errors", 32'(bad), 32'd0);
    check("clear ctrl read", 32'(v), 32'h01);
    rd(8'h81, v); check("clear col", 32'(v), 32'd0);
    rd(8'h82, v); check("clear row", 32'(v), 32'd0);

    // Clear with both CTRL bits set, writes attempted while busy.
    wr(8'h84, 8'h03);
    runClear(1'b1, pulses, busyCyc, bad, v);
    check("clear2 pulses", 32'(pulses), 32'(Cells));
    check("clear2 busy cycles", 32'(busyCyc), 32'(Cells));
    check("clear2 cell errors", 32'(bad), 32'd0);
    rd(8'h83, v); check("clear2 attr kept", 32'(v), 32'h1E);
    rd(8'h81, v); check("clear2 col", 32'(v), 32'd0);
    rd(8'h82, v); check("clear2 row", 32'(v), 32'd0);

    // Reset in the middle of a clear.
    wr(8'h81, 8'd9);
    wr(8'h84, 8'h01);
    repeat (50) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset dsp_wr", 32'(bus.dsp_wr), 32'd0);
    check("midreset busy", 32'(bus.busy), 32'd0);
    rd(8'h83, v); check("midreset attr", 32'(v), 32'h0F);
    rd(8'h81, v); check("midreset col", 32'(v), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.dsp_wr || bus.busy) pulses++;
    end
    check("midreset no resume", 32'(pulses), 32'd0);

    // Randomized traffic against the reference model (no clears).
    doReset();
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 7);
      d  = 8'($urandom);
      case (op)
        0, 1: id = 8'h80;
        2: begin id = 8'h81; d = 8'($urandom_range(0, 130)); end
        3: begin id = 8'h82; d = 8'($urandom_range(0, 45)); end
        4: id = 8'h83;
        5: begin id = 8'h84; d = (d & 8'hFC) | 8'h02; end
        6: id = 8'(8'h85 + $urandom_range(0, 2));
        default: begin
          id = 8'($urandom);
          if (id[7:3] == 5'b10000) id = id ^ 8'h40;
        end
      endcase
      eAddr = cellAddr(pos);
      eData = {mAttr, d};
      wr(id, d);
      check("rand dsp_wr", 32'(bus.dsp_wr), (op <= 1) ? 32'd1 : 32'd0);
      if (op <= 1) begin
        check("rand dsp_addr", 32'(bus.dsp_addr), 32'(eAddr));
        check("rand dsp_data", 32'(bus.dsp_data), 32'(eData));
      end
      case (op)
        0, 1: pos = (pos + 1) % Cells;
        2: pos = (pos / Cols) * Cols + ((int'(d) >= Cols) ? Cols - 1 : int'(d));
        3: pos = ((int'(d) >= Rows) ? Rows - 1 : int'(d)) * Cols + (pos % Cols);
        4: mAttr = d;
        5: pos = (((pos / Cols) + 1) % Rows) * Cols;
        default: ;
      endcase
      r = $urandom_range(1, 3);
      rd(8'(8'h80 + r), v);
      case (r)
        1: check("rand col", 32'(v), 32'(pos % Cols));
        2: check("rand row", 32'(v), 32'(pos / Cols));
        default: check("rand attr", 32'(v), 32'(mAttr));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
